data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 127 ++++++++++++
 tb/tb_data_memory.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// ----------------------------------------------------------------------------
// data_memory
//
// Single-port word-addressed data memory behind a req/gnt/rvalid load/store
// handshake. Grant may be withheld for a fixed number of cycles after a
// request appears. Each accepted transfer produces a one-cycle response
// exactly one cycle later. Out-of-range accesses produce an error response
// and never touch storage.
//
// Parameters
//   DEPTH      number of 32-bit words (power of two, >= 4)
//   BASE_ADDR  byte address of word 0 (DEPTH*4 aligned)
//   GNT_STALL  cycles grant is withheld after a request appears (0..15)
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   data_req_i     request valid
//   data_gnt_o     request accepted this cycle (combinational)
//   data_rvalid_o  response valid
//   data_addr_i    byte address (bits [1:0] ignored)
//   data_we_i      1 = write, 0 = read
//   data_wdata_i   write data
//   data_rdata_o   read data, zero unless a read response is presented
//   data_err_o     error flag, only ever set together with data_rvalid_o
// ----------------------------------------------------------------------------
module data_memory #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned GNT_STALL = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int          IDX_W       = $clog2(DEPTH);
    localparam logic [32:0] DEPTH_BYTES = 33'(DEPTH) << 2;
    localparam logic [3:0]  STALL       = 4'(GNT_STALL);

    // ------------------------------------------------------------------
    // Grant / stall counter
    // ------------------------------------------------------------------
    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;
    logic       xfer;

    // Reset forces grant low so nothing can be accepted while in reset.
    assign data_gnt_o = data_req_i && !rst_i && (cnt_reg == STALL);
    assign xfer       = data_gnt_o;

    always_comb begin
        cnt_next = cnt_reg;
        if (!data_req_i || data_gnt_o) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    // The offset is computed one bit wider than the address: an address
    // below BASE_ADDR borrows into bit 32 and so can never compare below
    // DEPTH_BYTES. This gives the unsigned, non-wrapping range check with a
    // single comparison.
    logic [32:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] word_idx;

    assign offset   = {1'b0, data_addr_i} - {1'b0, BASE_ADDR};
    assign in_range = (offset < DEPTH_BYTES);
    assign word_idx = offset[IDX_W+1:2];

    // ------------------------------------------------------------------
    // Storage: no reset so it maps onto block RAM; registered read port.
    // ------------------------------------------------------------------
    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_reg;

    always_ff @(posedge clk_i) begin
        if (xfer && in_range) begin
            if (data_we_i) begin
                mem[word_idx] <= data_wdata_i;
            end else begin
                rdata_reg <= mem[word_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response tracking
    // ------------------------------------------------------------------
    logic rvalid_reg;
    logic err_reg;
    logic rd_reg;   // response carries read data (in-range read)

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg    <= '0;
            rvalid_reg <= 1'b0;
            err_reg    <= 1'b0;
            rd_reg     <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            rvalid_reg <= xfer;
            err_reg    <= xfer && !in_range;
            rd_reg     <= xfer && in_range && !data_we_i;
        end
    end

    // Everything is qualified by rvalid_reg, which reset clears
    // asynchronously, so the response outputs go quiet as soon as reset
    // rises and a pending response is cancelled.
    assign data_rvalid_o = rvalid_reg;
    assign data_err_o    = rvalid_reg && err_reg;
    assign data_rdata_o  = (rvalid_reg && rd_reg) ? rdata_reg : 32'h0;

endmodule

// File: tb/tb_data_memory.sv
// ----------------------------------------------------------------------------
// tb_data_memory
//
// Three data_memory instances with different parameter sets:
//   u0: defaults (GNT_STALL=0, BASE_ADDR=0, DEPTH=1024)
//   u1: GNT_STALL=3
//   u2: BASE_ADDR=0x1000, DEPTH=16
// Stimulus tasks push the expected response into a per-instance queue at the
// grant; a monitor pops and compares whenever rvalid is seen, and checks the
// response latency and that idle outputs stay zero.
// ----------------------------------------------------------------------------
module tb_data_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  req, gnt, we, rvalid, err;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];

    data_memory u0 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req[0]), .data_gnt_o(gnt[0]),
        .data_rvalid_o(rvalid[0]), .data_addr_i(addr[0]), .data_we_i(we[0]),
        .data_wdata_i(wdata[0]), .data_rdata_o(rdata[0]), .data_err_o(err[0])
    );

    data_memory #(.GNT_STALL(3)) u1 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req[1]), .data_gnt_o(gnt[1]),
        .data_rvalid_o(rvalid[1]), .data_addr_i(addr[1]), .data_we_i(we[1]),
        .data_wdata_i(wdata[1]), .data_rdata_o(rdata[1]), .data_err_o(err[1])
    );

    data_memory #(.DEPTH(16), .BASE_ADDR(32'h0000_1000)) u2 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req[2]), .data_gnt_o(gnt[2]),
        .data_rvalid_o(rvalid[2]), .data_addr_i(addr[2]), .data_we_i(we[2]),
        .data_wdata_i(wdata[2]), .data_rdata_o(rdata[2]), .data_err_o(err[2])
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req_v);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        bit   has;
        for (int k = 0; k < 3; k++) begin
            if (rvalid[k] === 1'b1) begin
                has = 1'b0;
                case (k)
                    0: if (q0.size() > 0) begin e = q0.pop_front(); has = 1'b1; end
                    1: if (q1.size() > 0) begin e = q1.pop_front(); has = 1'b1; end
                    default: if (q2.size() > 0) begin e = q2.pop_front(); has = 1'b1; end
                endcase
                if (!has) begin
                    check($sformatf("u%0d unexpected rvalid at cycle %0d", k, cyc), 64'd1, 64'd0);
                end else begin
                    $display("u%0d rsp cycle=%0d rdata=0x%08h err=%0b (want 0x%08h/%0b)",
                             k, cyc, rdata[k], err[k], e.rdata, e.err);
                    check($sformatf("u%0d rsp cycle", k), 64'(cyc), 64'(e.due));
                    check($sformatf("u%0d rdata", k), 64'(rdata[k]), 64'(e.rdata));
                    check($sformatf("u%0d err", k), 64'(err[k]), 64'(e.err));
                end
            end else begin
                check($sformatf("u%0d idle outputs", k), {31'h0, err[k], rdata[k]}, 64'h0);
            end
        end
    end

    task automatic push(int k, logic [31:0] d, logic e);
        exp_t x;
        x.rdata = d;
        x.err   = e;
        x.due   = cyc + 1;
        case (k)
            0: q0.push_back(x);
            1: q1.push_back(x);
            default: q2.push_back(x);
        endcase
    endtask

    // Issue one transfer on instance k. With scr set, addr/we/wdata carry
    // decoy values until the cycle the grant is expected.
    task automatic issue(int k, logic [31:0] a, logic w, logic [31:0] wd,
                         logic [31:0] exp_d, logic exp_e, int exp_wait, bit scr);
        int waits = 0;
        req[k] = 1'b1;
        if (scr && exp_wait > 0) begin
            addr[k] = a ^ 32'h10; we[k] = ~w; wdata[k] = ~wd;
        end else begin
            addr[k] = a; we[k] = w; wdata[k] = wd;
        end
        forever begin
            @(negedge clk);
            if (gnt[k] === 1'b1) break;
            waits++;
            if (waits >= 40) break;
            @(posedge clk); #1;
            if (waits >= exp_wait) begin
                addr[k] = a; we[k] = w; wdata[k] = wd;
            end
        end
        $display("u%0d req addr=0x%08h we=%0b wdata=0x%08h waits=%0d", k, a, w, wd, waits);
        check($sformatf("u%0d gnt wait for 0x%08h", k, a), 64'(waits), 64'(exp_wait));
        if (gnt[k] === 1'b1) push(k, exp_d, exp_e);
        @(posedge clk); #1;
    endtask

    task automatic idle(int k);
        req[k] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        req = 3'b111;
        we  = 3'b000;
        for (int k = 0; k < 3; k++) begin
            addr[k]  = 32'h0;
            wdata[k] = 32'h0;
        end

        // Reset state: grant held low even with requests present.
        @(negedge clk);
        check("reset gnt", 64'(gnt), 64'h0);
        check("reset rvalid", 64'(rvalid), 64'h0);
        @(posedge clk); #1;
        req = 3'b000;
        rst = 1'b0;

        // u1 first, immediately after release: counter starts from 0.
        issue(1, 32'h4, 1'b1, 32'h0BAD_F00D, 32'h0, 1'b0, 3, 1'b1);
        issue(1, 32'h4, 1'b0, 32'h0, 32'h0BAD_F00D, 1'b0, 3, 1'b1);
        idle(1);
        // Request held two cycles, dropped, re-raised: count restarts.
        req[1] = 1'b1; addr[1] = 32'h4; we[1] = 1'b0;
        @(negedge clk); check("u1 gnt early 0", 64'(gnt[1]), 64'h0);
        @(posedge clk); #1;
        @(negedge clk); check("u1 gnt early 1", 64'(gnt[1]), 64'h0);
        @(posedge clk); #1;
        idle(1);
        issue(1, 32'h4, 1'b0, 32'h0, 32'h0BAD_F00D, 1'b0, 3, 1'b0);
        idle(1);

        // u0: write then read next cycle.
        issue(0, 32'h10, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 1'b0);
        issue(0, 32'h10, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        idle(0);
        // Unaligned address.
        issue(0, 32'h23, 1'b1, 32'hA5A5_A5A5, 32'h0, 1'b0, 0, 1'b0);
        idle(0);
        issue(0, 32'h20, 1'b0, 32'h0, 32'hA5A5_A5A5, 1'b0, 0, 1'b0);
        idle(0);
        // Back-to-back: 8 writes then 8 reads with req held.
        for (int i = 0; i < 8; i++)
            issue(0, 32'h100 + 32'(i * 4), 1'b1, 32'hC0DE_0000 + 32'(i * 17), 32'h0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 8; i++)
            issue(0, 32'h100 + 32'(i * 4), 1'b0, 32'h0, 32'hC0DE_0000 + 32'(i * 17), 1'b0, 0, 1'b0);
        idle(0);

        // u2: range checks.
        issue(2, 32'h1000, 1'b1, 32'h5A5A_0000, 32'h0, 1'b0, 0, 1'b0);
        issue(2, 32'h103C, 1'b1, 32'h1111_2222, 32'h0, 1'b0, 0, 1'b0);
        issue(2, 32'h0FFC, 1'b0, 32'h0, 32'h0, 1'b1, 0, 1'b0);
        issue(2, 32'h1040, 1'b0, 32'h0, 32'h0, 1'b1, 0, 1'b0);
        issue(2, 32'h1040, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 0, 1'b0);
        issue(2, 32'h103C, 1'b0, 32'h0, 32'h1111_2222, 1'b0, 0, 1'b0);
        issue(2, 32'h103F, 1'b0, 32'h0, 32'h1111_2222, 1'b0, 0, 1'b0);
        issue(2, 32'h1000, 1'b0, 32'h0, 32'h5A5A_0000, 1'b0, 0, 1'b0);
        idle(2);
        repeat (2) @(posedge clk);
        #1;

        // u0: reset right after a granted read cancels its response.
        issue(0, 32'h40, 1'b1, 32'h1234_5678, 32'h0, 1'b0, 0, 1'b0);
        issue(0, 32'h40, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 0, 1'b0);
        rst    = 1'b1;
        req[0] = 1'b0;
        #1;
        check("rvalid cleared by reset", 64'(rvalid[0]), 64'h0);
        q0.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        issue(0, 32'h40, 1'b1, 32'hCAFE_F00D, 32'h0, 1'b0, 0, 1'b0);
        issue(0, 32'h40, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, 0, 1'b0);
        idle(0);
        repeat (3) @(posedge clk);
        @(negedge clk);

        check("pending responses", 64'(q0.size() + q1.size() + q2.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
